// File: rtl/ibex_rf_checker.sv
// Response-side checker for the ibex register file bench: shadows the RF and compares both read ports.
// Optional build macro RF_CHK_STOP_ON_ERR_EN ends the run on the edge of the first mismatch.
module ibex_rf_checker #(
  parameter int unsigned          RV32E             = 0,
  parameter int unsigned          DataWidth         = 32,
  parameter int unsigned          DummyInstructions = 0,
  parameter logic [DataWidth-1:0] WordZeroVal       = '0,
  parameter int unsigned          NumChecks         = 0,
  parameter int unsigned          ErrCntWidth       = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic                   stop_i,
  input  logic                   dummy_instr_id_i,
  input  logic                   dummy_instr_wb_i,
  input  logic [4:0]             raddr_a_i,
  input  logic [4:0]             raddr_b_i,
  input  logic [DataWidth-1:0]   rdata_a_i,
  input  logic [DataWidth-1:0]   rdata_b_i,
  input  logic [4:0]             waddr_a_i,
  input  logic [DataWidth-1:0]   wdata_a_i,
  input  logic                   we_a_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   pass_o,
  output logic                   err_o,
  output logic [31:0]            chk_cnt_o,
  output logic [ErrCntWidth-1:0] err_cnt_o,
  output logic                   fail_port_o,
  output logic [4:0]             fail_addr_o,
  output logic [DataWidth-1:0]   fail_exp_o,
  output logic [DataWidth-1:0]   fail_got_o
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam int unsigned NumRegs = (RV32E != 0) ? 16 : 32;
  localparam int unsigned AddrW   = (RV32E != 0) ? 4 : 5;

  logic [1:0]             state_q, state_d;
  logic [DataWidth-1:0]   rf_q [NumRegs];
  logic [DataWidth-1:0]   rf_d [NumRegs];
  logic [31:0]            chk_cnt_q, chk_cnt_d;
  logic [ErrCntWidth-1:0] err_cnt_q, err_cnt_d;
  logic                   err_q, err_d;
  logic                   fail_seen_q, fail_seen_d;
  logic                   fail_port_q, fail_port_d;
  logic [4:0]             fail_addr_q, fail_addr_d;
  logic [DataWidth-1:0]   fail_exp_q, fail_exp_d;
  logic [DataWidth-1:0]   fail_got_q, fail_got_d;

  logic [4:0]             raddr [2];
  logic [DataWidth-1:0]   rdata [2];
  logic [DataWidth-1:0]   exp_data [2];
  logic [1:0]             skip;
  logic [1:0]             mism;
  logic [1:0]             n_chk;
  logic [1:0]             n_err;
  logic [32:0]            chk_sum;
  logic [ErrCntWidth:0]   err_sum;

  // Expected data comes from the pre-edge shadow, so a same-cycle write is never bypassed.
  always_comb begin
    raddr[0] = raddr_a_i;
    raddr[1] = raddr_b_i;
    rdata[0] = rdata_a_i;
    rdata[1] = rdata_b_i;
    skip     = '0;
    mism     = '0;
    for (int p = 0; p < 2; p++) begin
      skip[p] = (RV32E != 0) && raddr[p][4];
      if (raddr[p] == 5'd0) begin
        exp_data[p] = ((DummyInstructions != 0) && dummy_instr_id_i) ? rf_q[0] : WordZeroVal;
      end else begin
        exp_data[p] = rf_q[raddr[p][AddrW-1:0]];
      end
      mism[p] = !skip[p] && (rdata[p] != exp_data[p]);
    end
    n_chk = {1'b0, ~skip[0]} + {1'b0, ~skip[1]};
    n_err = {1'b0, mism[0]} + {1'b0, mism[1]};
  end

  always_comb begin
    state_d     = state_q;
    chk_cnt_d   = chk_cnt_q;
    err_cnt_d   = err_cnt_q;
    err_d       = 1'b0;
    fail_seen_d = fail_seen_q;
    fail_port_d = fail_port_q;
    fail_addr_d = fail_addr_q;
    fail_exp_d  = fail_exp_q;
    fail_got_d  = fail_got_q;
    rf_d        = rf_q;
    chk_sum     = {1'b0, chk_cnt_q} + {31'd0, n_chk};
    err_sum     = {1'b0, err_cnt_q} + {{(ErrCntWidth-1){1'b0}}, n_err};

    if (state_q == StRun) begin
      chk_cnt_d = chk_sum[32] ? '1 : chk_sum[31:0];
      err_cnt_d = err_sum[ErrCntWidth] ? '1 : err_sum[ErrCntWidth-1:0];
      err_d     = |mism;
      // Port A wins when both ports fail on the first failing cycle.
      if (!fail_seen_q && (|mism)) begin
        fail_seen_d = 1'b1;
        fail_port_d = ~mism[0];
        fail_addr_d = mism[0] ? raddr_a_i   : raddr_b_i;
        fail_exp_d  = mism[0] ? exp_data[0] : exp_data[1];
        fail_got_d  = mism[0] ? rdata_a_i   : rdata_b_i;
      end
      if (stop_i) begin
        state_d = StDone;
      end else if ((NumChecks != 0) && (chk_cnt_d >= NumChecks)) begin
        state_d = StDone;
      end
`ifdef RF_CHK_STOP_ON_ERR_EN
      if (|mism) begin
        state_d = StDone;
      end
`endif
    end else if (start_i) begin
      state_d     = StRun;
      chk_cnt_d   = '0;
      err_cnt_d   = '0;
      fail_seen_d = 1'b0;
      fail_port_d = 1'b0;
      fail_addr_d = '0;
      fail_exp_d  = '0;
      fail_got_d  = '0;
    end

    // Shadow tracking runs in every state so the model never drifts from the DUT.
    if (we_a_i && !((RV32E != 0) && waddr_a_i[4]) &&
        ((waddr_a_i != 5'd0) || ((DummyInstructions != 0) && dummy_instr_wb_i))) begin
      rf_d[waddr_a_i[AddrW-1:0]] = wdata_a_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      chk_cnt_q   <= '0;
      err_cnt_q   <= '0;
      err_q       <= 1'b0;
      fail_seen_q <= 1'b0;
      fail_port_q <= 1'b0;
      fail_addr_q <= '0;
      fail_exp_q  <= '0;
      fail_got_q  <= '0;
      for (int i = 0; i < NumRegs; i++) begin
        rf_q[i] <= WordZeroVal;
      end
    end else begin
      state_q     <= state_d;
      chk_cnt_q   <= chk_cnt_d;
      err_cnt_q   <= err_cnt_d;
      err_q       <= err_d;
      fail_seen_q <= fail_seen_d;
      fail_port_q <= fail_port_d;
      fail_addr_q <= fail_addr_d;
      fail_exp_q  <= fail_exp_d;
      fail_got_q  <= fail_got_d;
      rf_q        <= rf_d;
    end
  end

  assign busy_o      = (state_q == StRun);
  assign done_o      = (state_q == StDone);
  assign pass_o      = done_o && (err_cnt_q == '0);
  assign err_o       = err_q;
  assign chk_cnt_o   = chk_cnt_q;
  assign err_cnt_o   = err_cnt_q;
  assign fail_port_o = fail_port_q;
  assign fail_addr_o = fail_addr_q;
  assign fail_exp_o  = fail_exp_q;
  assign fail_got_o  = fail_got_q;

endmodule

// File: tb/tb_ibex_rf_checker.sv
// Bench for ibex_rf_checker: four configurations share one stimulus stream and a behavioural model.
module tb_ibex_rf_checker;

  localparam int NC = 4;
  localparam int unsigned P_RV32E [NC] = '{0, 0, 1, 0};
  localparam int unsigned P_DUMMY [NC] = '{0, 1, 0, 0};
  localparam int unsigned P_NCHK  [NC] = '{0, 0, 0, 4};

  logic        clk, rst, start, stop, dummy_id, dummy_wb, we;
  logic [4:0]  raddr_a, raddr_b, waddr;
  logic [31:0] rdata_a, rdata_b, wdata;

  logic        busy [NC];
  logic        done [NC];
  logic        pass [NC];
  logic        err  [NC];
  logic [31:0] chk_cnt [NC];
  logic [15:0] err_cnt [NC];
  logic        fail_port [NC];
  logic [4:0]  fail_addr [NC];
  logic [31:0] fail_exp [NC];
  logic [31:0] fail_got [NC];

  int n_total = 0;
  int n_pass  = 0;

  for (genvar g = 0; g < NC; g++) begin : g_dut
    ibex_rf_checker #(
      .RV32E(P_RV32E[g]),
      .DummyInstructions(P_DUMMY[g]),
      .NumChecks(P_NCHK[g])
    ) u_dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .stop_i(stop),
      .dummy_instr_id_i(dummy_id), .dummy_instr_wb_i(dummy_wb),
      .raddr_a_i(raddr_a), .raddr_b_i(raddr_b),
      .rdata_a_i(rdata_a), .rdata_b_i(rdata_b),
      .waddr_a_i(waddr), .wdata_a_i(wdata), .we_a_i(we),
      .busy_o(busy[g]), .done_o(done[g]), .pass_o(pass[g]), .err_o(err[g]),
      .chk_cnt_o(chk_cnt[g]), .err_cnt_o(err_cnt[g]),
      .fail_port_o(fail_port[g]), .fail_addr_o(fail_addr[g]),
      .fail_exp_o(fail_exp[g]), .fail_got_o(fail_got[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: 0 = idle, 1 = running, 2 = done
  int          m_state [NC];
  longint      m_chk [NC];
  int          m_err [NC];
  bit          m_errp [NC];
  bit          m_fseen [NC];
  bit          m_fport [NC];
  logic [4:0]  m_faddr [NC];
  logic [31:0] m_fexp [NC];
  logic [31:0] m_fgot [NC];
  logic [31:0] m_rf [NC][32];

  task automatic model_reset();
    for (int c = 0; c < NC; c++) begin
      m_state[c] = 0; m_chk[c] = 0; m_err[c] = 0; m_errp[c] = 0;
      m_fseen[c] = 0; m_fport[c] = 0; m_faddr[c] = '0; m_fexp[c] = '0; m_fgot[c] = '0;
      for (int r = 0; r < 32; r++) m_rf[c][r] = '0;
    end
  endtask

  function automatic bit m_skip(int c, logic [4:0] a);
    return (P_RV32E[c] != 0) && (a >= 5'd16);
  endfunction

  function automatic logic [31:0] m_read(int c, logic [4:0] a);
    if (a == 5'd0) return ((P_DUMMY[c] != 0) && dummy_id) ? m_rf[c][0] : 32'd0;
    return m_rf[c][a];
  endfunction

  task automatic model_edge();
    for (int c = 0; c < NC; c++) begin
      bit          mism;
      logic [4:0]  a;
      logic [31:0] got, want;
      mism = 0;
      if (m_state[c] == 1) begin
        for (int p = 0; p < 2; p++) begin
          a   = (p == 1) ? raddr_b : raddr_a;
          got = (p == 1) ? rdata_b : rdata_a;
          if (!m_skip(c, a)) begin
            want = m_read(c, a);
            m_chk[c] = m_chk[c] + 1;
            if (got !== want) begin
              if (m_err[c] < 65535) m_err[c] = m_err[c] + 1;
              if (!m_fseen[c]) begin
                m_fseen[c] = 1; m_fport[c] = (p == 1); m_faddr[c] = a;
                m_fexp[c] = want; m_fgot[c] = got;
              end
              mism = 1;
            end
          end
        end
        if (m_chk[c] > 64'hFFFF_FFFF) m_chk[c] = 64'hFFFF_FFFF;
        m_errp[c] = mism;
        if (stop) m_state[c] = 2;
        else if (P_NCHK[c] != 0 && m_chk[c] >= P_NCHK[c]) m_state[c] = 2;
`ifdef RF_CHK_STOP_ON_ERR_EN
        if (mism) m_state[c] = 2;
`endif
      end else begin
        m_errp[c] = 0;
        if (start) begin
          m_state[c] = 1; m_chk[c] = 0; m_err[c] = 0;
          m_fseen[c] = 0; m_fport[c] = 0; m_faddr[c] = '0; m_fexp[c] = '0; m_fgot[c] = '0;
        end
      end
      if (we && !m_skip(c, waddr) && (waddr != 5'd0 || (P_DUMMY[c] != 0 && dummy_wb)))
        m_rf[c][waddr] = wdata;
    end
  endtask

  function automatic logic [121:0] dut_status(int c);
    return {busy[c], done[c], pass[c], err[c], chk_cnt[c], err_cnt[c],
            fail_port[c], fail_addr[c], fail_exp[c], fail_got[c]};
  endfunction

  function automatic logic [121:0] model_status(int c);
    logic [31:0] ck;
    logic [15:0] ec;
    ck = 32'(m_chk[c]);
    ec = 16'(m_err[c]);
    return {m_state[c] == 1, m_state[c] == 2, (m_state[c] == 2) && (m_err[c] == 0), m_errp[c],
            ck, ec, m_fport[c], m_faddr[c], m_fexp[c], m_fgot[c]};
  endfunction

  task automatic idle_inputs();
    start = 0; stop = 0; dummy_id = 0; dummy_wb = 0; we = 0;
    raddr_a = '0; raddr_b = '0; waddr = '0;
    rdata_a = '0; rdata_b = '0; wdata = '0;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    #2;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    model_reset();
    #1;
    for (int c = 0; c < NC; c++) begin
      n_total++;
      if (dut_status(c) !== '0) $display("[TB] FAIL reset_state[%0d] got %h want 0", c, dut_status(c));
      else n_pass++;
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    do_reset();
    start = 1; we = 1; waddr = 5'd5; wdata = 32'hDEAD_BEEF;
    step();
    n_total++;
    if (busy[0] !== 1'b1) $display("[TB] FAIL basic_busy got %0b want 1", busy[0]); else n_pass++;
    start = 0; we = 0; raddr_a = 5'd5; raddr_b = 5'd0; rdata_a = 32'hDEAD_BEEF; rdata_b = '0;
    step();
    n_total++;
    if (chk_cnt[0] !== 32'd2) $display("[TB] FAIL basic_chk got %0d want 2", chk_cnt[0]); else n_pass++;
    n_total++;
    if (err_cnt[0] !== 16'd0) $display("[TB] FAIL basic_err got %0d want 0", err_cnt[0]); else n_pass++;
    stop = 1;
    step();
    stop = 0;
    n_total++;
    if ({done[0], pass[0]} !== 2'b11) $display("[TB] FAIL basic_pass got done/pass %b want 11", {done[0], pass[0]});
    else n_pass++;
  endtask

  task automatic test_no_bypass();
    do_reset();
    start = 1;
    step();
    start = 0; we = 1; waddr = 5'd7; wdata = 32'd1;
    raddr_a = 5'd7; raddr_b = 5'd0; rdata_a = '0; rdata_b = '0;
    step();
    n_total++;
    if ({err[0], err_cnt[0]} !== 17'd0) $display("[TB] FAIL nobypass_same got err %0b cnt %0d want 0 0", err[0], err_cnt[0]);
    else n_pass++;
    we = 0;
    step();
    n_total++;
    if (err[0] !== 1'b1) $display("[TB] FAIL nobypass_pulse got %0b want 1", err[0]); else n_pass++;
    n_total++;
    if ({fail_port[0], fail_addr[0], fail_exp[0], fail_got[0]} !== {1'b0, 5'd7, 32'd1, 32'd0})
      $display("[TB] FAIL nobypass_fail got port %0b addr %0d exp %h got %h want 0 7 1 0",
               fail_port[0], fail_addr[0], fail_exp[0], fail_got[0]);
    else n_pass++;
    raddr_a = 5'd0;
    step();
    n_total++;
    if (err[0] !== 1'b0) $display("[TB] FAIL nobypass_pulse_end got %0b want 0", err[0]); else n_pass++;
  endtask

  task automatic test_dummy();
    do_reset();
    start = 1; we = 1; waddr = 5'd0; wdata = 32'd5; dummy_wb = 1;
    step();
    start = 0; we = 0; dummy_wb = 0; dummy_id = 1;
    raddr_a = 5'd0; raddr_b = 5'd0; rdata_a = 32'd5; rdata_b = 32'd5;
    step();
    n_total++;
    if (err_cnt[1] !== 16'd0) $display("[TB] FAIL dummy_read_id1 got %0d want 0", err_cnt[1]); else n_pass++;
    n_total++;
    if ({fail_exp[0], fail_got[0]} !== {32'd0, 32'd5})
      $display("[TB] FAIL dummy_x0_plain got exp %h got %h want 0 5", fail_exp[0], fail_got[0]);
    else n_pass++;
    dummy_id = 0; rdata_a = '0; rdata_b = '0;
    step();
    n_total++;
    if (err_cnt[1] !== 16'd0) $display("[TB] FAIL dummy_read_id0 got %0d want 0", err_cnt[1]); else n_pass++;
    we = 1; waddr = 5'd0; wdata = 32'd9; dummy_wb = 0; dummy_id = 1; rdata_a = 32'd5; rdata_b = 32'd5;
    step();
    we = 0;
    step();
    n_total++;
    if ({chk_cnt[1], err_cnt[1]} !== {32'd8, 16'd0})
      $display("[TB] FAIL dummy_nowb got chk %0d err %0d want 8 0", chk_cnt[1], err_cnt[1]);
    else n_pass++;
  endtask

  task automatic test_rv32e();
    do_reset();
    start = 1;
    step();
    start = 0; raddr_a = 5'd20; raddr_b = 5'd3; rdata_a = 32'h55; rdata_b = '0;
    we = 1; waddr = 5'd20; wdata = 32'h1234;
    step();
    we = 0;
    n_total++;
    if ({chk_cnt[2], err_cnt[2]} !== {32'd1, 16'd0})
      $display("[TB] FAIL rv32e_skip got chk %0d err %0d want 1 0", chk_cnt[2], err_cnt[2]);
    else n_pass++;
    raddr_a = 5'd4; raddr_b = 5'd20; rdata_a = '0; rdata_b = '0;
    step();
    n_total++;
    if ({chk_cnt[2], err_cnt[2]} !== {32'd2, 16'd0})
      $display("[TB] FAIL rv32e_nowrite got chk %0d err %0d want 2 0", chk_cnt[2], err_cnt[2]);
    else n_pass++;
  endtask

  task automatic test_both_wrong();
    do_reset();
    start = 1;
    step();
    start = 0; raddr_a = 5'd5; raddr_b = 5'd6; rdata_a = 32'd1; rdata_b = 32'd2;
    step();
    n_total++;
    if ({err[0], err_cnt[0], fail_port[0], fail_addr[0], fail_got[0]} !== {1'b1, 16'd2, 1'b0, 5'd5, 32'd1})
      $display("[TB] FAIL both_first got err %0b cnt %0d port %0b addr %0d got %h want 1 2 0 5 1",
               err[0], err_cnt[0], fail_port[0], fail_addr[0], fail_got[0]);
    else n_pass++;
    raddr_a = 5'd8; rdata_a = 32'd3;
    step();
    stop = 1; raddr_a = 5'd0; raddr_b = 5'd0; rdata_a = '0; rdata_b = '0;
    step();
    stop = 0;
    n_total++;
    if ({done[0], pass[0], fail_addr[0]} !== {1'b1, 1'b0, 5'd5})
      $display("[TB] FAIL both_end got done %0b pass %0b addr %0d want 1 0 5", done[0], pass[0], fail_addr[0]);
    else n_pass++;
`ifdef RF_CHK_STOP_ON_ERR_EN
    n_total++;
    if (err_cnt[0] !== 16'd2) $display("[TB] FAIL both_stop_cnt got %0d want 2", err_cnt[0]); else n_pass++;
`else
    n_total++;
    if (err_cnt[0] !== 16'd4) $display("[TB] FAIL both_cont_cnt got %0d want 4", err_cnt[0]); else n_pass++;
`endif
  endtask

  task automatic test_numchecks();
    do_reset();
    start = 1;
    step();
    start = 0; raddr_a = 5'd1; raddr_b = 5'd2; rdata_a = '0; rdata_b = '0;
    step();
    n_total++;
    if ({busy[3], done[3], chk_cnt[3]} !== {1'b1, 1'b0, 32'd2})
      $display("[TB] FAIL numchk_mid got busy %0b done %0b chk %0d want 1 0 2", busy[3], done[3], chk_cnt[3]);
    else n_pass++;
    step();
    n_total++;
    if ({busy[3], done[3], pass[3], chk_cnt[3]} !== {1'b0, 1'b1, 1'b1, 32'd4})
      $display("[TB] FAIL numchk_done got busy %0b done %0b pass %0b chk %0d want 0 1 1 4",
               busy[3], done[3], pass[3], chk_cnt[3]);
    else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    start = 1; we = 1; waddr = 5'd5; wdata = 32'hABCD;
    step();
    start = 0; we = 0; raddr_a = 5'd1; rdata_a = 32'd3;
    step();
    step();
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    for (int c = 0; c < NC; c++) begin
      n_total++;
      if (dut_status(c) !== '0) $display("[TB] FAIL midrun_reset[%0d] got %h want 0", c, dut_status(c));
      else n_pass++;
    end
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    step();
    n_total++;
    if ({busy[0], chk_cnt[0]} !== 33'd0) $display("[TB] FAIL midrun_idle got busy %0b chk %0d want 0 0", busy[0], chk_cnt[0]);
    else n_pass++;
    start = 1;
    step();
    start = 0; raddr_a = 5'd5; rdata_a = '0;
    step();
    n_total++;
    if ({chk_cnt[0], err_cnt[0]} !== {32'd2, 16'd0})
      $display("[TB] FAIL midrun_shadow_clear got chk %0d err %0d want 2 0", chk_cnt[0], err_cnt[0]);
    else n_pass++;
  endtask

  task automatic test_random();
    do_reset();
    start = 1;
    step();
    for (int i = 0; i < 400; i++) begin
      start    = ($urandom_range(0, 15) == 0);
      stop     = ($urandom_range(0, 39) == 0);
      dummy_id = ($urandom_range(0, 3) == 0);
      dummy_wb = ($urandom_range(0, 3) == 0);
      we       = $urandom_range(0, 1);
      waddr    = 5'($urandom_range(0, 31));
      wdata    = $urandom;
      raddr_a  = 5'($urandom_range(0, 31));
      raddr_b  = 5'($urandom_range(0, 31));
      rdata_a  = m_read(0, raddr_a);
      rdata_b  = m_read(0, raddr_b);
      if ($urandom_range(0, 7) == 0) rdata_a = rdata_a ^ (32'd1 << $urandom_range(0, 31));
      if ($urandom_range(0, 7) == 0) rdata_b = rdata_b ^ (32'd1 << $urandom_range(0, 31));
      step();
      for (int c = 0; c < NC; c++) begin
        n_total++;
        if (dut_status(c) !== model_status(c))
          $display("[TB] FAIL random_status[%0d] cycle %0d got %h want %h", c, i, dut_status(c), model_status(c));
        else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_no_bypass();
    test_dummy();
    test_rv32e();
    test_both_wrong();
    test_numchecks();
    test_reset_mid_run();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
